// File: rtl/systolic_mm.sv
// Output-stationary rows_p x cols_p systolic matrix multiplier: streams K A-columns/B-rows,
// accumulates C = A*B in place, then drains results row-major over a valid/ready port.
module systolic_pe #(
  parameter int width_p     = 8,
  parameter int acc_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clr_i,
  input  logic                   signed_i,
  input  logic [width_p:0]       a_i,      // {valid, operand}
  input  logic [width_p:0]       b_i,
  output logic [acc_width_p-1:0] acc_o
);
  logic        [2*width_p-1:0]   prod_u;
  logic signed [2*width_p-1:0]   prod_s;
  logic        [acc_width_p-1:0] prod_x;

  assign prod_u = {{width_p{1'b0}}, a_i[width_p-1:0]} * {{width_p{1'b0}}, b_i[width_p-1:0]};
  assign prod_s = $signed({{width_p{a_i[width_p-1]}}, a_i[width_p-1:0]}) *
                  $signed({{width_p{b_i[width_p-1]}}, b_i[width_p-1:0]});
  assign prod_x = signed_i ? acc_width_p'(prod_s) : acc_width_p'(prod_u);

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i)                acc_o <= '0;
    else if (clr_i)                acc_o <= '0;
    else if (a_i[width_p] && b_i[width_p]) acc_o <= acc_o + prod_x;
endmodule

module systolic_mm #(
  parameter int width_p     = 8,
  parameter int acc_width_p = 32,   // must be >= 2*width_p
  parameter int rows_p      = 2,
  parameter int cols_p      = 2,
  parameter int k_max_p     = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  input  logic [$clog2(k_max_p+1)-1:0]  k_i,
  input  logic                          signed_i,
  output logic                          busy_o,
  input  logic [rows_p*width_p-1:0]     a_i,
  input  logic [cols_p*width_p-1:0]     b_i,
  input  logic                          ab_valid_i,
  output logic                          ab_ready_o,
  output logic [acc_width_p-1:0]        z_o,
  output logic [(rows_p>1 ? $clog2(rows_p) : 1)-1:0] z_row_o,
  output logic [(cols_p>1 ? $clog2(cols_p) : 1)-1:0] z_col_o,
  output logic                          z_valid_o,
  input  logic                          z_ready_i,
  output logic                          done_o
);
  localparam int KW = $clog2(k_max_p+1);
  localparam int RW = rows_p > 1 ? $clog2(rows_p) : 1;
  localparam int CW = cols_p > 1 ? $clog2(cols_p) : 1;
  localparam int FW = $clog2(rows_p+cols_p);
  localparam logic [KW-1:0] K_MAX = KW'(k_max_p);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state;
  logic [KW-1:0] k_q, beat_q;
  logic          signed_q, done_q;
  logic [FW-1:0] flush_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  logic start_ok, accept, last_beat, last_z;
  logic [rows_p-1:0][cols_p-1:0][width_p:0]       a_tap, b_tap;
  logic [rows_p-1:0][cols_p-1:0][acc_width_p-1:0] acc;

  assign start_ok  = (state == S_IDLE) && start_i && (k_i != '0) && (k_i <= K_MAX);
  assign accept    = (state == S_FEED) && ab_valid_i;
  assign last_beat = (beat_q + KW'(1)) == k_q;
  assign last_z    = (row_q == RW'(rows_p-1)) && (col_q == CW'(cols_p-1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= S_IDLE;
      k_q      <= '0;
      beat_q   <= '0;
      signed_q <= 1'b0;
      flush_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == S_DRAIN) && z_ready_i && last_z;
      case (state)
        S_IDLE: if (start_ok) begin
          k_q      <= k_i;
          signed_q <= signed_i;
          beat_q   <= '0;
          state    <= S_FEED;
        end
        S_FEED: if (accept) begin
          beat_q <= beat_q + KW'(1);
          if (last_beat) begin
            flush_q <= '0;
            state   <= S_FLUSH;
          end
        end
        // Wait for the last beat to ripple through to the far-corner PE.
        S_FLUSH: if (flush_q == FW'(rows_p+cols_p-2)) begin
          row_q <= '0;
          col_q <= '0;
          state <= S_DRAIN;
        end else begin
          flush_q <= flush_q + FW'(1);
        end
        S_DRAIN: if (z_ready_i) begin
          if (last_z) state <= S_IDLE;
          else if (col_q == CW'(cols_p-1)) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PE(r,c) sees row r's operand after r+c+1 registers: r skew stages plus c hops.
  for (genvar r = 0; r < rows_p; r++) begin : g_arow
    localparam int LEN = r + cols_p;
    logic [LEN-1:0][width_p:0] vld_pipe;
    always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) vld_pipe <= '0;
      else begin
        vld_pipe[0] <= {accept, a_i[width_p*r +: width_p]};
        for (int j = 1; j < LEN; j++) vld_pipe[j] <= vld_pipe[j-1];
      end
    for (genvar c = 0; c < cols_p; c++) begin : g_tap
      assign a_tap[r][c] = vld_pipe[r+c];
    end
  end

  for (genvar c = 0; c < cols_p; c++) begin : g_bcol
    localparam int LEN = c + rows_p;
    logic [LEN-1:0][width_p:0] vld_pipe;
    always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) vld_pipe <= '0;
      else begin
        vld_pipe[0] <= {accept, b_i[width_p*c +: width_p]};
        for (int j = 1; j < LEN; j++) vld_pipe[j] <= vld_pipe[j-1];
      end
    for (genvar r = 0; r < rows_p; r++) begin : g_tap
      assign b_tap[r][c] = vld_pipe[r+c];
    end
  end

  for (genvar r = 0; r < rows_p; r++) begin : g_pr
    for (genvar c = 0; c < cols_p; c++) begin : g_pc
      systolic_pe #(.width_p(width_p), .acc_width_p(acc_width_p)) u_pe (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (start_ok),
        .signed_i  (signed_q),
        .a_i       (a_tap[r][c]),
        .b_i       (b_tap[r][c]),
        .acc_o     (acc[r][c])
      );
    end
  end

  assign busy_o     = state != S_IDLE;
  assign ab_ready_o = state == S_FEED;
  assign z_valid_o  = state == S_DRAIN;
  assign z_o        = z_valid_o ? acc[row_q][col_q] : '0;
  assign z_row_o    = z_valid_o ? row_q : '0;
  assign z_col_o    = z_valid_o ? col_q : '0;
  assign done_o     = done_q;
endmodule

// File: doc/systolic_mm.md
SYSTOLIC_MM -- requirements
Module: systolic_mm

Interface
REQ-001 SHALL have parameters: width_p, default 8, operand width; acc_width_p, default 32, accumulator width, legal only if acc_width_p >= 2*width_p; rows_p, default 2, PE rows; cols_p, default 2, PE columns; k_max_p, default 16, maximum reduction depth.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-003 SHALL have port reset_n_i, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit, job start request.
REQ-005 SHALL have port k_i, input, $clog2(k_max_p+1) bits, job reduction depth K, sampled with start.
REQ-006 SHALL have port signed_i, input, 1 bit, 1 = two's-complement operands, sampled with start.
REQ-007 SHALL have port busy_o, output, 1 bit, high when the block is not in IDLE.
REQ-008 SHALL have port a_i, input, rows_p*width_p bits, one A column; element r at bits [width_p*(r+1)-1 : width_p*r].
REQ-009 SHALL have port b_i, input, cols_p*width_p bits, one B row; element c at bits [width_p*(c+1)-1 : width_p*c].
REQ-010 SHALL have port ab_valid_i, input, 1 bit, a_i/b_i beat valid.
REQ-011 SHALL have port ab_ready_o, output, 1 bit, beat accepted when ab_valid_i & ab_ready_o.
REQ-012 SHALL have port z_o, output, acc_width_p bits, drained result.
REQ-013 SHALL have port z_row_o, output, $clog2(rows_p) bits (min 1), row index of z_o.
REQ-014 SHALL have port z_col_o, output, $clog2(cols_p) bits (min 1), column index of z_o.
REQ-015 SHALL have port z_valid_o, output, 1 bit, result valid.
REQ-016 SHALL have port z_ready_i, input, 1 bit, result taken when z_valid_o & z_ready_i.
REQ-017 SHALL have port done_o, output, 1 bit, one-cycle job-complete pulse.

Function
REQ-018 SHALL implement FSM IDLE -> FEED -> FLUSH -> DRAIN -> IDLE.
REQ-019 IDLE: start_i=1 with k_i in 1..k_max_p SHALL latch K and signed_i, clear all rows_p*cols_p accumulators and enter FEED; start_i with k_i=0 or k_i>k_max_p SHALL be ignored.
REQ-020 start_i outside IDLE SHALL be ignored; latched mode and K SHALL not change mid-job.
REQ-021 FEED: ab_ready_o=1; the block SHALL accept exactly K beats and SHALL tolerate any gaps in ab_valid_i; on the K-th accept it SHALL enter FLUSH; ab_ready_o SHALL be 0 in every other state.
REQ-022 Skew: row r operand SHALL be delayed r stages and column c operand c stages, each carrying a valid bit; the pipeline SHALL advance every cycle, and bubbles SHALL carry valid=0.
REQ-023 A beat accepted at edge T SHALL be accumulated into PE(r,c) at edge T+1+r+c, as acc[r][c] += a_k[r]*b_k[c].
REQ-024 Arithmetic: the product SHALL be width 2*width_p, sign-extended (signed) or zero-extended (unsigned) to acc_width_p, and summed modulo 2^acc_width_p with wrap and no saturation.
REQ-025 FLUSH SHALL last exactly rows_p+cols_p-1 cycles and then enter DRAIN.
REQ-026 DRAIN: results SHALL be presented in row-major order (0,0),(0,1)...(rows_p-1,cols_p-1) with z_valid_o=1 and matching z_row_o/z_col_o; the index SHALL advance only on z_valid_o & z_ready_i.
REQ-027 While z_valid_o=1 and z_ready_i=0, z_o/z_row_o/z_col_o SHALL hold stable.
REQ-028 When z_valid_o=0, z_o, z_row_o and z_col_o SHALL be 0.
REQ-029 The final drain transfer SHALL return the FSM to IDLE, and done_o SHALL be 1 for exactly the following cycle.
REQ-030 A start_i in the cycle done_o is high SHALL be accepted, with IDLE already reached.

Reset
REQ-031 reset_n_i=0 SHALL immediately and asynchronously force IDLE, clear accumulators, skew registers, counters and latched mode, and drive busy_o, ab_ready_o, z_valid_o, z_o, z_row_o, z_col_o and done_o to 0, including mid-job; after release, no residual results SHALL be produced.

Verification (rows_p=cols_p=2, width_p=8, acc_width_p=32)
REQ-032 Unsigned, K=2, beats a=(1,3)/b=(5,6) then a=(2,4)/b=(7,8), z_ready_i=1 -> z_o = 19, 22, 43, 50 at (0,0),(0,1),(1,0),(1,1), then a done_o pulse.
REQ-033 Signed, K=1, a=(0xFF,0x02), b=(0x03,0xFC) -> 0xFFFFFFFD, 0x00000004, 0x00000006, 0xFFFFFFF8; the same bytes unsigned -> 765, 64260, 6, 504.
REQ-034 Backpressure and gaps: K=2 with a 3-cycle ab_valid_i gap, and z_ready_i low for 5 cycles during DRAIN -> identical results to REQ-032; z_o held stable; no skipped or duplicated indices.
REQ-035 Latency: K=1 accepted at edge T -> FLUSH spans 3 cycles; the first z_valid_o=1 occurs in the cycle after edge T+3.
REQ-036 start_i with k_i=0, and start_i while busy -> no state change. reset_n_i low mid-FEED -> all outputs 0 at once. Next job K=1 with all operands 1 -> four results of 1.
